iterative_arithmetic_unit: RTL and testbench



---
 rtl/iterative_arithmetic_unit.sv | 183 ++++++++++++++++++
 tb/tb_iterative_arithmetic_unit.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/iterative_arithmetic_unit.sv
// Multi-cycle signed multiply/divide engine: shift-add multiplier and restoring
// divider sharing one datapath, one bit per clock, beside the execute-stage ALU.

package iterative_arithmetic_unit_pkg;
  typedef struct packed {
    logic carry;
    logic zero;
    logic negative;
    logic overflow;
    logic parity;
  } sFlags;

  typedef enum logic [1:0] {
    OP_MUL = 2'b00,
    OP_MUH = 2'b01,
    OP_DIV = 2'b10,
    OP_MOD = 2'b11
  } op_e;
endpackage

module iterative_arithmetic_unit
  import iterative_arithmetic_unit_pkg::*;
#(
  parameter int DataWidth = 16
) (
  input  logic                 Clock,
  input  logic                 nReset,
  input  logic                 Start,
  input  logic [1:0]           Op,
  input  logic [DataWidth-1:0] InSrc,
  input  logic [DataWidth-1:0] InDest,
  input  sFlags                InFlags,
  output logic                 Busy,
  output logic                 Done,
  output logic [DataWidth-1:0] OutDest,
  output sFlags                OutFlags,
  output logic                 DivByZero
);
  localparam int CountWidth = $clog2(DataWidth) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e                r_state, w_state_next;
  op_e                   r_op;
  logic                  r_carry, r_neg, r_dneg, r_dz, r_dovf;
  logic [DataWidth-1:0]  r_hi, r_lo, r_opb;
  logic [CountWidth-1:0] r_count;
  logic                  r_done, r_div_by_zero;
  logic [DataWidth-1:0]  r_out_dest;
  sFlags                 r_out_flags;

  logic                   w_accept, w_div_zero, w_unused_flags;
  logic [DataWidth-1:0]   w_src_mag, w_dest_mag;
  logic [DataWidth:0]     w_sum, w_shift;
  logic                   w_ge;
  logic [DataWidth-1:0]   w_diff;
  logic [2*DataWidth-1:0] w_prod, w_prod_s;
  logic                   w_mul_ovf;
  logic [DataWidth-1:0]   w_result;
  logic                   w_ovf;

  // Busy is low in DONE, so a request arriving there starts the next op back-to-back.
  assign w_accept       = Start && (r_state != S_RUN);
  assign w_div_zero     = Op[1] && (InSrc == '0);
  assign w_src_mag      = InSrc[DataWidth-1]  ? -InSrc  : InSrc;
  assign w_dest_mag     = InDest[DataWidth-1] ? -InDest : InDest;
  assign w_unused_flags = ^{InFlags.zero, InFlags.negative, InFlags.overflow, InFlags.parity};

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  // NOTE: next state is defaulted first so no path through the case can infer a latch.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (Start) w_state_next = w_div_zero ? S_DONE : S_RUN;
        else       w_state_next = S_IDLE;
      end
      S_RUN:   if (r_count == CountWidth'(1)) w_state_next = S_DONE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Multiply: {r_hi,r_lo} accumulates and shifts right; divide: r_hi is the partial remainder.
  assign w_sum   = {1'b0, r_hi} + ({1'b0, r_opb} & {(DataWidth+1){r_lo[0]}});
  assign w_shift = {r_hi, r_lo[DataWidth-1]};
  assign w_ge    = (w_shift >= {1'b0, r_opb});
  assign w_diff  = w_shift[DataWidth-1:0] - r_opb;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_op    <= OP_MUL;
      r_carry <= 1'b0;
      r_neg   <= 1'b0;
      r_dneg  <= 1'b0;
      r_dz    <= 1'b0;
      r_dovf  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_opb   <= '0;
      r_count <= '0;
    end else if (w_accept) begin
      r_op    <= op_e'(Op);
      r_carry <= InFlags.carry;
      r_neg   <= InSrc[DataWidth-1] ^ InDest[DataWidth-1];
      r_dneg  <= InDest[DataWidth-1];
      r_dz    <= w_div_zero;
      r_dovf  <= (Op == OP_DIV) && (InDest == {1'b1, {(DataWidth-1){1'b0}}}) && (InSrc == '1);
      r_count <= CountWidth'(DataWidth);
      r_hi    <= '0;
      r_lo    <= Op[1] ? w_dest_mag : w_src_mag;
      r_opb   <= Op[1] ? w_src_mag  : w_dest_mag;
    end else if (r_state == S_RUN) begin
      r_count <= r_count - CountWidth'(1);
      if (r_op[1]) begin
        r_hi <= w_ge ? w_diff : w_shift[DataWidth-1:0];
        r_lo <= {r_lo[DataWidth-2:0], w_ge};
      end else begin
        {r_hi, r_lo} <= {w_sum, r_lo[DataWidth-1:1]};
      end
    end
  end

  assign w_prod    = {r_hi, r_lo};
  assign w_prod_s  = r_neg ? -w_prod : w_prod;
  assign w_mul_ovf = (w_prod_s[2*DataWidth-1:DataWidth] != {DataWidth{w_prod_s[DataWidth-1]}});

  always_comb begin
    w_result = '0;
    w_ovf    = 1'b0;
    unique case (r_op)
      OP_MUL: begin
        w_result = w_prod_s[DataWidth-1:0];
        w_ovf    = w_mul_ovf;
      end
      OP_MUH: begin
        w_result = w_prod_s[2*DataWidth-1:DataWidth];
        w_ovf    = w_mul_ovf;
      end
      OP_DIV: begin
        w_result = r_dz ? '1 : (r_neg ? -r_lo : r_lo);
        w_ovf    = r_dz | r_dovf;
      end
      OP_MOD: begin
        // On divide-by-zero r_lo still holds |dividend|, so re-signing it returns InDest.
        w_result = r_dz ? (r_dneg ? -r_lo : r_lo) : (r_dneg ? -r_hi : r_hi);
        w_ovf    = r_dz;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_done        <= 1'b0;
      r_out_dest    <= '0;
      r_out_flags   <= '0;
      r_div_by_zero <= 1'b0;
    end else begin
      r_done <= (r_state == S_DONE);
      if (r_state == S_DONE) begin
        r_out_dest           <= w_result;
        r_out_flags.carry    <= r_carry;
        r_out_flags.zero     <= (w_result == '0);
        r_out_flags.negative <= w_result[DataWidth-1];
        r_out_flags.overflow <= w_ovf;
        r_out_flags.parity   <= ~^w_result;
        r_div_by_zero        <= r_dz;
      end
    end
  end

  assign Busy      = (r_state == S_RUN);
  assign Done      = r_done;
  assign OutDest   = r_out_dest;
  assign OutFlags  = r_out_flags;
  assign DivByZero = r_div_by_zero;

endmodule

// File: tb/tb_iterative_arithmetic_unit.sv
// Self-checking bench: directed vectors with literal expectations plus an
// integer-arithmetic reference model compared against the DUT every cycle.

module tb_iterative_arithmetic_unit;
  import iterative_arithmetic_unit_pkg::*;

  localparam int W = 16;

  logic         Clock = 1'b0;
  logic         nReset = 1'b0;
  logic         Start = 1'b0;
  logic [1:0]   Op = 2'b00;
  logic [W-1:0] InSrc = '0;
  logic [W-1:0] InDest = '0;
  sFlags        InFlags = '0;
  logic         Busy, Done, DivByZero;
  logic [W-1:0] OutDest;
  sFlags        OutFlags;

  iterative_arithmetic_unit #(.DataWidth(W)) dut (
    .Clock(Clock), .nReset(nReset), .Start(Start), .Op(Op),
    .InSrc(InSrc), .InDest(InDest), .InFlags(InFlags),
    .Busy(Busy), .Done(Done), .OutDest(OutDest), .OutFlags(OutFlags),
    .DivByZero(DivByZero)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [W-1:0] res;
    sFlags        fl;
    logic         dz;
    int           acc;
    int           due;
  } exp_t;

  exp_t         q[$];
  int           cyc = 0;
  int           n_checks = 0;
  int           n_pass = 0;
  logic [W-1:0] held_res = '0;
  sFlags        held_fl = '0;
  logic         held_dz = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    else n_pass++;
  endtask

  // Reference model: plain signed integer arithmetic.
  function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] src,
                                 input logic [W-1:0] dest, input logic carry);
    exp_t    e;
    int      a, b, r;
    longint  p;
    logic [W-1:0] lo;
    logic    ovf;
    a = int'($signed(dest));
    b = int'($signed(src));
    e.dz = 1'b0; e.res = '0; e.acc = 0; e.due = 0; ovf = 1'b0;
    case (op)
      2'b00, 2'b01: begin
        p   = longint'(a) * longint'(b);
        lo  = p[15:0];
        ovf = (p != longint'($signed(lo)));
        e.res = (op == 2'b00) ? p[15:0] : p[31:16];
      end
      2'b10: begin
        if (b == 0) begin e.res = 16'hFFFF; ovf = 1'b1; e.dz = 1'b1; end
        else if (a == -32768 && b == -1) begin e.res = 16'h8000; ovf = 1'b1; end
        else begin r = a / b; e.res = r[15:0]; end
      end
      default: begin
        if (b == 0) begin e.res = dest; ovf = 1'b1; e.dz = 1'b1; end
        else begin r = a % b; e.res = r[15:0]; end
      end
    endcase
    e.fl.carry    = carry;
    e.fl.zero     = (e.res == 0);
    e.fl.negative = e.res[15];
    e.fl.overflow = ovf;
    e.fl.parity   = ~^e.res;
    return e;
  endfunction

  always @(posedge Clock) cyc <= cyc + 1;

  // Compare process: every cycle checks Busy, Done timing, results and output holding.
  always @(negedge Clock) begin : cmp
    exp_t e;
    logic exp_busy;
    if (!nReset) begin
      q.delete();
      held_res <= '0;
      held_fl  <= '0;
      held_dz  <= 1'b0;
      check("reset_busy", Busy, 0);
      check("reset_done", Done, 0);
      check("reset_dest", OutDest, 0);
      check("reset_flags", OutFlags, 0);
      check("reset_dbz", DivByZero, 0);
    end else begin
      exp_busy = 1'b0;
      foreach (q[i]) if (!q[i].dz && cyc >= q[i].acc && cyc <= q[i].acc + W - 1) exp_busy = 1'b1;
      check("busy", Busy, exp_busy);
      if (Done) begin
        if (q.size() == 0) begin
          check("spurious_done", Done, 0);
        end else begin
          e = q.pop_front();
          check("done_cycle", cyc, e.due);
          check("result", OutDest, e.res);
          check("flags", OutFlags, e.fl);
          check("div_by_zero", DivByZero, e.dz);
          held_res <= e.res;
          held_fl  <= e.fl;
          held_dz  <= e.dz;
        end
      end else begin
        check("hold_dest", OutDest, held_res);
        check("hold_flags", OutFlags, held_fl);
        check("hold_dbz", DivByZero, held_dz);
        if (q.size() != 0 && cyc > q[0].due) begin
          check("done_missing", Done, 1);
          void'(q.pop_front());
        end
      end
      if (Start && !exp_busy) begin
        e = model(Op, InSrc, InDest, InFlags.carry);
        e.acc = cyc + 1;
        e.due = e.acc + (e.dz ? 1 : W + 1);
        q.push_back(e);
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [W-1:0] src,
                       input logic [W-1:0] dest, input logic carry);
    @(posedge Clock); #2;
    Start = 1'b1; Op = op; InSrc = src; InDest = dest;
    InFlags = sFlags'({carry, 4'b0101});
    @(posedge Clock); #2;
    Start = 1'b0; Op = 2'b11; InSrc = 16'hDEAD; InDest = 16'hBEEF; InFlags = '1;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clock);
      if (Done) begin lat = i; break; end
    end
    check("done_seen", Done, 1);
  endtask

  task automatic run(input logic [1:0] op, input logic [W-1:0] src, input logic [W-1:0] dest,
                     input logic carry, input logic [W-1:0] exp_res, input logic exp_ovf,
                     input int exp_lat);
    int lat;
    issue(op, src, dest, carry);
    wait_done(lat);
    check("lit_latency", lat, exp_lat);
    check("lit_result", OutDest, exp_res);
    check("lit_overflow", OutFlags.overflow, exp_ovf);
    check("lit_carry", OutFlags.carry, carry);
    check("lit_dbz", DivByZero, (exp_lat == 1));
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    exp_t e;
    int   lat;
    int   done_cnt;

    e = model(2'b00, 16'hFFF9, 16'd300, 1'b0);
    check("model_mul", e.res, 16'hF7CC);
    e = model(2'b10, 16'd2, 16'hFFF9, 1'b0);
    check("model_div", e.res, 16'hFFFD);
    e = model(2'b11, 16'd2, 16'hFFF9, 1'b0);
    check("model_mod", e.res, 16'hFFFF);
    e = model(2'b10, 16'hFFFF, 16'h8000, 1'b0);
    check("model_divovf", {e.res, e.fl.overflow}, {16'h8000, 1'b1});

    repeat (3) @(posedge Clock);
    #2 nReset = 1'b1;

    run(2'b00, 16'hFFF9, 16'd300, 1'b1, 16'hF7CC, 1'b0, W + 1);
    check("mul_neg", OutFlags.negative, 1);
    check("mul_zero", OutFlags.zero, 0);
    run(2'b01, 16'h0004, 16'h4000, 1'b0, 16'h0001, 1'b1, W + 1);
    run(2'b00, 16'h0004, 16'h4000, 1'b0, 16'h0000, 1'b1, W + 1);
    check("mul_zero_flag", OutFlags.zero, 1);
    run(2'b10, 16'd2, 16'hFFF9, 1'b0, 16'hFFFD, 1'b0, W + 1);
    run(2'b11, 16'd2, 16'hFFF9, 1'b1, 16'hFFFF, 1'b0, W + 1);
    check("mod_neg", OutFlags.negative, 1);
    run(2'b11, 16'hFFFE, 16'd7, 1'b0, 16'h0001, 1'b0, W + 1);
    run(2'b10, 16'h0000, 16'h1234, 1'b0, 16'hFFFF, 1'b1, 1);
    run(2'b11, 16'h0000, 16'h1234, 1'b1, 16'h1234, 1'b1, 1);

    // Most-negative / -1, then a new Start pulsed while Done is high.
    issue(2'b10, 16'hFFFF, 16'h8000, 1'b0);
    repeat (W + 1) @(posedge Clock);
    #2;
    check("b2b_done", Done, 1);
    check("b2b_first", OutDest, 16'h8000);
    check("b2b_first_flags", {OutFlags.overflow, OutFlags.negative}, 2'b11);
    Start = 1'b1; Op = 2'b00; InSrc = 16'd45; InDest = 16'd123; InFlags = '0;
    @(posedge Clock); #2;
    Start = 1'b0;
    @(negedge Clock);
    check("b2b_busy", Busy, 1);
    wait_done(lat);
    check("b2b_second", OutDest, 16'h159F);

    // Start during RUN must be ignored.
    issue(2'b00, 16'hFFFD, 16'd1000, 1'b1);
    repeat (5) @(posedge Clock);
    #2;
    Start = 1'b1; Op = 2'b10; InSrc = 16'd5; InDest = 16'd77;
    @(posedge Clock); #2;
    Start = 1'b0;
    wait_done(lat);
    check("ignored_start", OutDest, 16'hF448);

    // Reset in the middle of RUN aborts the operation.
    issue(2'b10, 16'd7, 16'd1000, 1'b0);
    repeat (4) @(posedge Clock);
    #2 nReset = 1'b0;
    #1;
    check("abort_busy", Busy, 0);
    check("abort_dest", OutDest, 0);
    repeat (2) @(posedge Clock);
    #2 nReset = 1'b1;
    done_cnt = 0;
    repeat (25) begin
      @(negedge Clock);
      if (Done) done_cnt++;
    end
    check("abort_no_done", done_cnt, 0);
    check("abort_dest_zero", OutDest, 0);
    check("abort_flags_zero", OutFlags, 0);

    run(2'b00, 16'd3, 16'hFFFE, 1'b0, 16'hFFFA, 1'b0, W + 1);

    repeat (3) @(negedge Clock);
    check("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
